replay_ipg_shaper: RTL and testbench
====================================

# replay_ipg_shaper

Downstream stage of the pcap replay micro-engine. Sits on the AXI-Stream path between the engine's FIFO-to-AXI output and the port. It passes packets through unchanged and enforces a programmable idle gap, in clock cycles, after every packet. It also stops the replay after a programmable number of packets and reports the number of packets sent.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, tdata width, same on both sides; tstrb width is C_M_AXIS_DATA_WIDTH/8.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width, same on both sides.
- CNT_WIDTH, 32, width of ipg_cycles, pkt_limit and pkt_cnt.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata / tstrb / tuser / tlast  in  DATA / DATA/8 / TUSER / 1  packet stream from the replay engine.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- m_axis_tdata / tstrb / tuser / tlast  out  DATA / DATA/8 / TUSER / 1  shaped stream.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- enable  in  1  run control, level-sensitive.
- ipg_cycles  in  CNT_WIDTH  idle cycles forced after each packet; 0 means back-to-back.
- pkt_limit  in  CNT_WIDTH  packets to send before stopping; 0 means unlimited.
- pkt_cnt  out  CNT_WIDTH  packets completed since the last start.
- done  out  1  high while in DONE.
- busy  out  1  high in PASS or GAP.

## Operation
- The datapath is pure pass-through; tdata, tstrb, tuser and tlast go from s to m combinationally.
- Define open = (state==PASS).
- m_axis_tvalid = s_axis_tvalid & open.
- s_axis_tready = m_axis_tready & open.
- Define beat = m_axis_tvalid & m_axis_tready.
- Define eop = beat & tlast.
- in_pkt flag: set on any beat without tlast; cleared on eop.
- States:
  - IDLE: gate closed. Goes to PASS when enable=1. On this transition pkt_cnt clears to 0 and in_pkt clears.
  - PASS: gate open. Transitions are evaluated in this priority order:
    - On eop, pkt_cnt increments, saturating at all-ones.
    - If pkt_limit!=0 and the pre-increment pkt_cnt+1 >= pkt_limit, go to DONE.
    - Else if enable=0, go to IDLE.
    - Else if ipg_cycles!=0, load gap_cnt=ipg_cycles and go to GAP.
    - Else stay in PASS.
    - With no eop in the cycle: if enable=0 and in_pkt=0, go to IDLE. A packet already in progress always completes before the block leaves PASS.
  - GAP: gate closed. gap_cnt decrements each cycle.
    - enable=0 goes to IDLE immediately.
    - When gap_cnt==1, go to PASS, so GAP lasts exactly ipg_cycles cycles.
  - DONE: gate closed. Stays until enable=0, then goes to IDLE. pkt_cnt holds its value.
- ipg_cycles is sampled only on eop. pkt_limit is compared live. Changing either mid-gap does not affect the gap currently running.
- pkt_cnt+1 is computed at CNT_WIDTH+1 bits, so the comparison is correct when pkt_cnt is all-ones.
- Lowering pkt_limit below pkt_cnt takes effect at the next eop, which then goes to DONE.

## Timing
- Reset values: state=IDLE, pkt_cnt=0, gap_cnt=0, in_pkt=0, done=0, busy=0, m_axis_tvalid=0, s_axis_tready=0.
- m_axis_tdata, tstrb, tuser and tlast mirror their s_axis inputs at all times, including during reset.
- Latency:
  - Zero cycles through the data path.
  - Gate reopens: the first cycle after eop with ipg_cycles=0, or ipg_cycles+1 cycles after the eop cycle otherwise.
  - State, pkt_cnt, done and busy are registered. They update on the clock edge after the event.
- The gate is a function of registered state only. It never depends combinationally on s_axis_tvalid, so there is no valid→ready loop.
- A stall (m_axis_tready=0) in PASS holds the state. Gap counting happens only in GAP.
- If reset is asserted mid-packet, the stream is truncated. On the next cycle the block is in IDLE with the gate closed; recovering from the truncated packet is upstream's job.
- If enable drops and eop occurs in the same cycle, pkt_cnt increments and the block goes to IDLE, or to DONE if the limit is reached.

## Test plan
- Back-to-back: enable=1, ipg_cycles=0, pkt_limit=0, three 4-beat packets with m_axis_tready=1 → 12 consecutive output beats, pkt_cnt=3, busy=1 throughout, done=0.
- Gap: ipg_cycles=5, two 2-beat packets offered continuously → exactly 5 cycles with m_axis_tvalid=0 and s_axis_tready=0 between the two tlast/first-beat cycles.
- Limit: pkt_limit=2, ipg_cycles=3, four packets offered → only 2 pass. done=1 one cycle after the second eop, pkt_cnt=2, s_axis_tready stays 0 afterwards. Setting enable=0 → IDLE, done=0; setting enable=1 again → pkt_cnt=0.
- Mid-packet disable: enable drops on beat 2 of a 6-beat packet → beats 3–6 still pass, then IDLE. Deasserting enable during GAP → IDLE on the next cycle.
- Backpressure: m_axis_tready toggled randomly with ipg_cycles=4 → output equals input beat-for-beat and the gap is still exactly 4 cycles.
- Saturation and reset: preset pkt_cnt to all-ones via a long run (or force in the bench), then one more eop → pkt_cnt stays all-ones. Asserting reset mid-packet → all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/replay_ipg_shaper_if.sv
// AXI-Stream bundle used on both sides of the IPG shaper.
interface replay_ipg_shaper_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tstrb, tuser, tlast, tvalid, input  tready);
  modport slave  (input  tdata, tstrb, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/replay_ipg_shaper.sv
// Replay IPG shaper: pass-through AXI-Stream gate that inserts a fixed idle
// gap after every packet, stops after a packet limit and counts packets.
module replay_ipg_shaper #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  replay_ipg_shaper_if.slave   s_axis,
  replay_ipg_shaper_if.master  m_axis,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] ipg_cycles,
  input  logic [CNT_WIDTH-1:0] pkt_limit,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, PASS, GAP, DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_pkt_cnt;
  logic [CNT_WIDTH-1:0]   r_gap_cnt;
  logic                   r_in_pkt;

  logic                   w_open, w_beat, w_eop, w_limit_hit;
  logic                   w_start, w_load_gap;
  logic [CNT_WIDTH:0]     w_cnt_p1;

  logic [C_M_AXIS_DATA_WIDTH-1:0]   w_tdata;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] w_tstrb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  w_tuser;

  // Data path is wire-through; only the handshake is gated.
  assign w_tdata       = s_axis.tdata;
  assign w_tstrb       = s_axis.tstrb;
  assign w_tuser       = s_axis.tuser;
  assign m_axis.tdata  = w_tdata;
  assign m_axis.tstrb  = w_tstrb;
  assign m_axis.tuser  = w_tuser;
  assign m_axis.tlast  = s_axis.tlast;

  // Gate depends on registered state only, so there is no valid->ready path.
  assign w_open        = (r_state == PASS);
  assign m_axis.tvalid = s_axis.tvalid & w_open;
  assign s_axis.tready = m_axis.tready & w_open;

  assign w_beat = s_axis.tvalid & w_open & m_axis.tready;
  assign w_eop  = w_beat & s_axis.tlast;

  // One extra bit so an all-ones count still compares correctly.
  assign w_cnt_p1    = {1'b0, r_pkt_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_limit_hit = (pkt_limit != '0) && (w_cnt_p1 >= {1'b0, pkt_limit});

  assign pkt_cnt = r_pkt_cnt;
  assign done    = (r_state == DONE);
  assign busy    = (r_state == PASS) || (r_state == GAP);

  // Next-state decode; an in-flight packet always finishes before leaving PASS.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load_gap  = 1'b0;
    case (r_state)
      IDLE: if (enable) begin
        w_state_nxt = PASS;
        w_start     = 1'b1;
      end
      PASS: begin
        if (w_eop) begin
          if (w_limit_hit)              w_state_nxt = DONE;
          else if (!enable)             w_state_nxt = IDLE;
          else if (ipg_cycles != '0) begin
            w_state_nxt = GAP;
            w_load_gap  = 1'b1;
          end
        end else if (!enable && !r_in_pkt) begin
          w_state_nxt = IDLE;
        end
      end
      GAP: begin
        if (!enable)                             w_state_nxt = IDLE;
        else if (r_gap_cnt == CNT_WIDTH'(1))     w_state_nxt = PASS;
      end
      DONE: if (!enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Packet counter: cleared on start, saturating increment on eop.
  always_ff @(posedge clk) begin
    if (reset)                           r_pkt_cnt <= '0;
    else if (w_start)                    r_pkt_cnt <= '0;
    else if (w_eop && (r_pkt_cnt != '1)) r_pkt_cnt <= w_cnt_p1[CNT_WIDTH-1:0];
  end

  // Gap counter: ipg_cycles captured at eop, counts down only while in GAP.
  always_ff @(posedge clk) begin
    if (reset)                                     r_gap_cnt <= '0;
    else if (w_load_gap)                           r_gap_cnt <= ipg_cycles;
    else if ((r_state == GAP) && (r_gap_cnt != '0)) r_gap_cnt <= r_gap_cnt - CNT_WIDTH'(1);
  end

  // In-packet tracker: set by a non-last beat, cleared by eop or a new start.
  always_ff @(posedge clk) begin
    if (reset)        r_in_pkt <= 1'b0;
    else if (w_start) r_in_pkt <= 1'b0;
    else if (w_beat)  r_in_pkt <= ~s_axis.tlast;
  end

endmodule

// File: tb/tb_replay_ipg_shaper.sv
// Directed bench for replay_ipg_shaper: back-to-back, gap, limit, disable,
// backpressure, counter saturation and mid-packet reset.
module tb_replay_ipg_shaper;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [CW-1:0] ipg_cycles, pkt_limit, pkt_cnt;
  logic done, busy;

  replay_ipg_shaper_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  replay_ipg_shaper_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  replay_ipg_shaper #(
    .C_M_AXIS_DATA_WIDTH(DW), .C_M_AXIS_TUSER_WIDTH(UW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .s_axis(s_if.slave), .m_axis(m_if.master),
    .enable(enable), .ipg_cycles(ipg_cycles), .pkt_limit(pkt_limit),
    .pkt_cnt(pkt_cnt), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int pkt_seq = 0;
  bit bp_en = 1'b0;

  logic [31:0] exp_q[$], obs_q[$];
  int obs_cyc[$], gaps[$];
  int cyc = 0, closed_run = 0;
  bit after_eop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Output monitor: logs beats and idle-gate runs between packets.
  always @(negedge clk) begin
    cyc++;
    if (m_if.tvalid && m_if.tready) begin
      obs_q.push_back(m_if.tdata);
      obs_cyc.push_back(cyc);
      if (after_eop) gaps.push_back(closed_run);
      after_eop  = m_if.tlast;
      closed_run = 0;
    end else if (after_eop && !m_if.tvalid && s_if.tvalid) begin
      closed_run++;
    end
  end

  // Random downstream stalls.
  always @(posedge clk) begin
    #1;
    if (bp_en) m_if.tready = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mon_clr();
    obs_q.delete(); exp_q.delete(); obs_cyc.delete(); gaps.delete();
    after_eop = 1'b0; closed_run = 0;
  endtask

  // Offer npk packets of len beats back to back; enable drops with beat drop_at.
  task automatic offer(input int npk, input int len, input int drop_at);
    for (int p = 0; p < npk; p++) begin
      for (int b = 0; b < len; b++) begin
        int w;
        logic [31:0] tok;
        tok = {pkt_seq[15:0], b[15:0]};
        s_if.tdata  = tok;
        s_if.tuser  = pkt_seq[7:0];
        s_if.tstrb  = '1;
        s_if.tlast  = (b == len - 1);
        s_if.tvalid = 1'b1;
        if (b == drop_at) enable = 1'b0;
        exp_q.push_back(tok);
        w = 0;
        #1;
        while (!s_if.tready && w < 300) begin
          @(posedge clk); #2;
          w++;
        end
        if (w >= 300) begin
          chk("offer_ready", 32'(s_if.tready), 32'd1);
          s_if.tvalid = 1'b0;
          return;
        end
        step();
      end
      pkt_seq++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic cmp_stream(input string tag);
    int bad;
    bad = -1;
    chk({tag, "_n"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i] && bad < 0) bad = i;
    chk({tag, "_data"}, 32'(bad), 32'hFFFF_FFFF);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ipg_cycles = '0; pkt_limit = '0;
    s_if.tdata = 32'hDEAD_BEEF; s_if.tstrb = '1; s_if.tuser = 8'h5A;
    s_if.tlast = 1'b1; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
    repeat (3) step();
    #1;
    chk("rst_tdata", m_if.tdata, 32'hDEAD_BEEF);
    chk("rst_tlast", 32'(m_if.tlast), 32'd1);
    chk("rst_mvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_sready", 32'(s_if.tready), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    reset = 1'b0;
    step();

    // Back-to-back: three 4-beat packets, no gap.
    enable = 1'b1;
    step();
    mon_clr();
    offer(3, 4, -1);
    #1;
    cmp_stream("b2b");
    if (obs_cyc.size() == 12) chk("b2b_span", 32'(obs_cyc[11] - obs_cyc[0]), 32'd11);
    else chk("b2b_span_n", 32'(obs_cyc.size()), 32'd12);
    chk("b2b_cnt", 32'(pkt_cnt), 32'd3);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);

    // Gap of 5 between two 2-beat packets.
    ipg_cycles = 8'd5;
    mon_clr();
    offer(2, 2, -1);
    #1;
    cmp_stream("gap");
    chk("gap_n", 32'(gaps.size()), 32'd1);
    if (gaps.size() > 0) chk("gap_len", 32'(gaps[0]), 32'd5);
    chk("gap_busy", 32'(busy), 32'd1);

    // Limit of 2 with ipg 3; restart first so the count starts at zero.
    enable = 1'b0;
    step(); #1;
    chk("stop_busy", 32'(busy), 32'd0);
    pkt_limit = 8'd2; ipg_cycles = 8'd3; enable = 1'b1;
    step(); #1;
    chk("start_cnt0", 32'(pkt_cnt), 32'd0);
    mon_clr();
    offer(2, 2, -1);
    #1;
    chk("lim_done", 32'(done), 32'd1);
    chk("lim_cnt", 32'(pkt_cnt), 32'd2);
    cmp_stream("lim");
    mon_clr();
    s_if.tvalid = 1'b1; s_if.tlast = 1'b1;
    repeat (6) step();
    #1;
    chk("lim_sready", 32'(s_if.tready), 32'd0);
    chk("lim_nobeats", 32'(obs_q.size()), 32'd0);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    enable = 1'b0;
    step(); #1;
    chk("lim_idle_done", 32'(done), 32'd0);
    chk("lim_idle_cnt", 32'(pkt_cnt), 32'd2);
    enable = 1'b1;
    step(); #1;
    chk("lim_restart_cnt", 32'(pkt_cnt), 32'd0);

    // Mid-packet disable: enable drops on beat 2 of 6.
    pkt_limit = '0; ipg_cycles = '0;
    mon_clr();
    offer(1, 6, 1);
    #1;
    cmp_stream("mid");
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_cnt", 32'(pkt_cnt), 32'd1);

    // Disable during GAP leaves on the next cycle.
    enable = 1'b1;
    step();
    ipg_cycles = 8'd10;
    mon_clr();
    offer(1, 1, -1);
    #1;
    chk("ingap_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    step(); #1;
    chk("gapoff_busy", 32'(busy), 32'd0);
    chk("gapoff_done", 32'(done), 32'd0);

    // Backpressure with ipg 4.
    enable = 1'b1; ipg_cycles = 8'd4;
    step();
    mon_clr();
    bp_en = 1'b1;
    offer(3, 3, -1);
    bp_en = 1'b0;
    step();
    m_if.tready = 1'b1;
    #1;
    cmp_stream("bp");
    chk("bp_gaps_n", 32'(gaps.size()), 32'd2);
    if (gaps.size() == 2) begin
      chk("bp_gap0", 32'(gaps[0]), 32'd4);
      chk("bp_gap1", 32'(gaps[1]), 32'd4);
    end
    chk("bp_cnt", 32'(pkt_cnt), 32'd3);

    // Saturation: 255 single-beat packets, one more, then a limit of all-ones.
    enable = 1'b0;
    step();
    enable = 1'b1; ipg_cycles = '0;
    step();
    mon_clr();
    offer(255, 1, -1);
    #1;
    chk("sat_cnt255", 32'(pkt_cnt), 32'd255);
    offer(1, 1, -1);
    #1;
    chk("sat_hold", 32'(pkt_cnt), 32'd255);
    chk("sat_nodone", 32'(done), 32'd0);
    pkt_limit = 8'hFF;
    offer(1, 1, -1);
    #1;
    chk("sat_lim_done", 32'(done), 32'd1);
    chk("sat_lim_cnt", 32'(pkt_cnt), 32'd255);

    // Reset in the middle of a packet.
    enable = 1'b0; pkt_limit = '0;
    step();
    enable = 1'b1;
    step();
    offer(1, 1, -1);
    s_if.tdata = 32'h1111_0000; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    #1;
    chk("rmid_ready", 32'(s_if.tready), 32'd1);
    step();
    s_if.tdata = 32'hA5A5_0001;
    reset = 1'b1;
    step(); #1;
    chk("rmid_mvalid", 32'(m_if.tvalid), 32'd0);
    chk("rmid_sready", 32'(s_if.tready), 32'd0);
    chk("rmid_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rmid_cnt", 32'(pkt_cnt), 32'd0);
    chk("rmid_tdata", m_if.tdata, 32'hA5A5_0001);
    reset = 1'b0; s_if.tvalid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
